// File: rtl/tsc_pkg.sv
// Shared types and constants for the trigger-condition counter.
package tsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRED = 2'd2
  } tsc_state_t;

  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Width of the inactivity (idle) counter.
  localparam int IDLE_W = 16;

endpackage

// File: rtl/tsc_cond.sv
// Mask/mode reduction of the monitored rare signals (combinational).
module tsc_cond
  import tsc_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            i_mode,
  input  logic [N_CH-1:0] i_mask,
  input  logic [N_CH-1:0] i_r,
  output logic            o_cond
);

  logic [N_CH-1:0] w_and_t;
  logic [N_CH-1:0] w_or_t;

  // Per-channel terms: unmasked channels are transparent to the AND.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_and_t[g] = i_r[g] | ~i_mask[g];
    assign w_or_t[g]  = i_r[g] &  i_mask[g];
  end

  // An empty mask must never satisfy the AND form.
  assign o_cond = (i_mode == MODE_OR) ? (|w_or_t) : ((&w_and_t) & (|i_mask));

endmodule

// File: rtl/tsc_multi.sv
// Multi-channel rare-event trigger counter: prescaler-gated hit counting
// towards THRESH with optional inactivity timeout and a sticky trigger.
module tsc_multi
  import tsc_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PRE_W   = 8,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 128,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_arm,
  input  logic             i_clr,
  input  logic             i_mode,
  input  logic [N_CH-1:0]  i_mask,
  input  logic [N_CH-1:0]  i_r,
  output logic             o_trigger,
  output logic [CNT_W-1:0] o_count,
  output logic [1:0]       o_state,
  output logic             o_hit
);

  if (THRESH < 1 || THRESH >= (1 << CNT_W)) begin : g_bad_thresh
    $error("tsc_multi: THRESH must lie in 1..2^CNT_W-1");
  end
  if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("tsc_multi: TIMEOUT must lie in 0..65535");
  end

  localparam logic [CNT_W-1:0]  THR_M1 = CNT_W'(THRESH - 1);
  localparam logic [IDLE_W-1:0] TO_M1  = IDLE_W'(TIMEOUT - 1);
  localparam bit                TO_ON  = (TIMEOUT != 0);

  tsc_state_t        r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [CNT_W-1:0]  r_count;
  logic [IDLE_W-1:0] r_idle;
  logic              r_trigger;
  logic              r_hit;

  logic w_cond;
  logic w_gate;
  logic w_hit_c;
  logic w_fire;
  logic w_timeout;

  tsc_cond #(.N_CH(N_CH)) u_cond (
    .i_mode (i_mode),
    .i_mask (i_mask),
    .i_r    (i_r),
    .o_cond (w_cond)
  );

  assign w_gate    = r_pre[PRE_W-1];
  assign w_hit_c   = w_cond & w_gate & i_en & (r_state == ST_COUNT) & ~i_clr;
  assign w_fire    = (r_count == THR_M1);
  // Timeout only advances on enabled cycles, so it is also only taken on them.
  assign w_timeout = TO_ON & i_en & (r_idle == TO_M1);

  // Free-running prescaler, frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst)       r_pre <= '0;
    else if (i_en) r_pre <= r_pre + 1'b1;
  end

  // One-cycle pulse per counted hit.
  always_ff @(posedge clk) begin
    if (rst) r_hit <= 1'b0;
    else     r_hit <= w_hit_c;
  end

  // FSM with count / idle counter; priority clr > hit > timeout > arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_idle    <= '0;
      r_trigger <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count   <= '0;
          r_idle    <= '0;
          r_trigger <= 1'b0;
          if (i_arm) r_state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (i_clr) begin
            r_count <= '0;
            r_idle  <= '0;
          end else if (w_hit_c) begin
            r_count <= r_count + 1'b1;
            r_idle  <= '0;
            if (w_fire) begin
              r_state   <= ST_FIRED;
              r_trigger <= 1'b1;
            end
          end else if (w_timeout) begin
            r_count <= '0;
            r_idle  <= '0;
          end else if (!i_arm) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_idle  <= '0;
          end else if (i_en) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        ST_FIRED: begin
          if (i_clr) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_idle    <= '0;
            r_trigger <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_trigger = r_trigger;
  assign o_count   = r_count;
  assign o_state   = r_state;
  assign o_hit     = r_hit;

endmodule

// File: doc/tsc_multi.md
# tsc_multi

Parametrised trigger-condition counter for the AES trojan-insertion benchmarks, successor to the single-pair rare-event counter. It watches N_CH rare internal signals through a run-time mask and AND/OR combine mode, qualifies matches with a free-running prescaler gate, and counts matches towards a threshold with an optional inactivity timeout. A three-state FSM drives a sticky `trigger` consumed by the payload logic.

## Interface
- `N_CH`, 4: number of monitored signals.
- `PRE_W`, 8: prescaler width; gate = prescaler MSB.
- `CNT_W`, 8: event counter width.
- `THRESH`, 128: hit count that fires; legal range 1..2^CNT_W-1.
- `TIMEOUT`, 0: cycles without a hit in COUNT before `count` clears; 0 disables; legal range 0..2^16-1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; low freezes the prescaler and timeout counter and blocks hits.
- `arm`  in  1  level; high leaves IDLE.
- `clr`  in  1  pulse; clears `count` and returns FIRED to IDLE.
- `mode`  in  1  0 = AND of masked inputs, 1 = OR of masked inputs.
- `mask`  in  N_CH  channel select.
- `r`  in  N_CH  rare signals.
- `trigger`  out  1  sticky fire flag, registered.
- `count`  out  CNT_W  current hit count, registered.
- `state`  out  2  IDLE=0, COUNT=1, FIRED=2.
- `hit`  out  1  registered one-cycle pulse per counted hit.

## Operation
- Prescaler `pre`: PRE_W bits, increments each cycle when `en`=1 and wraps. Runs in all states. `gate` = `pre[PRE_W-1]`, using the current registered value.
- Condition `cond`:
  - mode 0: AND over masked channels of `r`. `mask`=0 forces `cond`=0.
  - mode 1: OR of `r & mask`.
- Hit: `hit_c` = `cond & gate & en & (state==COUNT) & !clr`.
- IDLE:
  - `count`=0, idle counter=0.
  - Goes to COUNT on `arm`=1.
- COUNT:
  - On `hit_c`, `count` increments. If `count+1==THRESH`, the next state is FIRED and `trigger` is set on the same edge.
  - Idle counter: 16 bits. It resets on `hit_c`. Otherwise it increments when `en`=1. If TIMEOUT≠0 and it reaches TIMEOUT-1, then on the next edge `count` and the idle counter clear and the state stays COUNT.
  - `arm`=0 returns to IDLE and clears `count`.
- FIRED:
  - `trigger`=1 and `count` holds THRESH.
  - `arm` is ignored.
  - Only `clr` or `rst` leave FIRED, both going to IDLE.
- `clr` priority:
  - In COUNT, `clr` clears `count` and the idle counter and the state stays COUNT.
  - `clr` beats a simultaneous hit and a simultaneous timeout.
- Priority per edge: `rst` > `clr` > hit/fire > timeout > `arm` transitions.
- `count` never wraps. FIRED entry at THRESH makes saturation implicit.

## Timing
- Reset value 0 for `pre`, `count`, idle counter, `trigger`, `hit`, and `state` (IDLE).
- `rst` during COUNT or FIRED returns everything to reset values on that edge.
- `hit`, `count` and `trigger` update on the edge that samples `hit_c`, so they are visible one cycle after the inputs.
- IDLE→COUNT takes effect one edge after `arm` is sampled high. Hits in that sampling cycle are not counted.
- `mode` and `mask` are combinational into `cond` and may change any cycle.
- Gate duty: high for 2^(PRE_W-1) of every 2^PRE_W enabled cycles.

## Structure
- Shared package `tsc_pkg`:
  - state enum (IDLE/COUNT/FIRED, 2 bits);
  - mode encodings (`MODE_AND`=0, `MODE_OR`=1);
  - idle counter width constant (16).
- One sub-module `tsc_cond`: mask/mode reduction over N_CH, purely combinational. The top level holds the prescaler, counters and FSM.
- Elaboration-time assertion: 1 ≤ THRESH < 2^CNT_W.

## Test plan
All scenarios use default parameters unless stated.
- Basic fire: hold `rst`, then release with `arm`=1, `en`=1, `mode`=0, `mask`=0011, `r`=0011 constant. Required: first `hit` when `pre`=128; `count` reaches 128 and `trigger` rises after the edge sampling `pre`=255; `state`=2; the trigger stays high over the next 1000 cycles.
- Mask and mode: `mask`=0000 in mode 0 must give no hits, `count`=0. Mode 1 with `mask`=1000 and `r`=1000 must hit; `r`=0111 must not.
- Timeout: TIMEOUT=50, `r` toggled so hits stop at `count`=10. Required: `count` returns to 0 exactly 50 enabled cycles after the last hit, and `state` stays 1.
- `clr` versus hit: assert `clr` in a cycle where `hit_c` would be true. Required: `count`=0 and `hit`=0 next cycle. `clr` in FIRED gives `trigger`=0 and `state`=0 next cycle.
- `en` freeze: drop `en` for 300 cycles mid-count with `count`=40. Required: `pre`, `count` and the idle counter hold; counting resumes identically afterwards.
- Reset mid-operation: pulse `rst` in COUNT with `count`=77. Required: all outputs 0 and `state`=0 next cycle.
